// File: rtl/soc_bootcopy_pkg.sv
// Shared types and AHB-Lite constants for the boot copy engine.
package soc_bootcopy_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_DATA,
      VR_ADDR,
      VR_DATA,
      DONE,
      ERROR
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/soc_ahb_single_xfer.sv
// One AHB-Lite single transfer: drives the address phase while requested and
// decodes hready/hresp into address-accept, data-ok and data-error events.
module soc_ahb_single_xfer
   import soc_bootcopy_pkg::*;
#(
   parameter int PLEN = 32
) (
   input  logic            addr_phase,
   input  logic            data_phase,
   input  logic [PLEN-1:0] addr,
   input  logic            write,
   input  logic            hready,
   input  logic            hresp,
   output logic [PLEN-1:0] haddr,
   output logic            hwrite,
   output logic [1:0]      htrans,
   output logic            addr_done,
   output logic            data_ok,
   output logic            data_err
);

   // Address-phase signals; bus parks at IDLE/address 0 outside the address phase
   always_comb begin
      haddr  = '0;
      hwrite = 1'b0;
      htrans = HTRANS_IDLE;
      if (addr_phase) begin
         haddr  = addr;
         hwrite = write;
         htrans = HTRANS_NONSEQ;
      end
   end

   assign addr_done = addr_phase & hready;
   assign data_ok   = data_phase & hready & ~hresp;
   assign data_err  = data_phase & hready & hresp;

endmodule

// File: rtl/soc_bootcopy.sv
// Boot-time copy engine: copies WORDS words from the boot ROM window to SRAM
// over AHB-Lite, holding the CPU in reset until the image is in place.
// Optional: define SOC_BOOTCOPY_VERIFY_EN to read back and compare each word.
module soc_bootcopy
   import soc_bootcopy_pkg::*;
#(
   parameter int              PLEN     = 32,
   parameter int              XLEN     = 32,
   parameter logic [PLEN-1:0] SRC_BASE = '0,
   parameter logic [PLEN-1:0] DST_BASE = PLEN'(32'h8000_0000),
   parameter int              WORDS    = 64
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PLEN-1:0] ahb4_haddr_o,
   output logic [XLEN-1:0] ahb4_hwdata_o,
   output logic            ahb4_hwrite_o,
   output logic [2:0]      ahb4_hsize_o,
   output logic [2:0]      ahb4_hburst_o,
   output logic [3:0]      ahb4_hprot_o,
   output logic [1:0]      ahb4_htrans_o,
   output logic            ahb4_hmastlock_o,
   input  logic [XLEN-1:0] ahb4_hrdata_i,
   input  logic            ahb4_hready_i,
   input  logic            ahb4_hresp_i,
   output logic            cpu_rst_o,
   output logic            done_o,
   output logic            error_o
);

   localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   state_t            state, state_nxt;
   logic [IDXW-1:0]   idx, idx_nxt;
   logic [XLEN-1:0]   data_q, data_nxt;
   logic              addr_phase, data_phase, xfer_write;
   logic [PLEN-1:0]   xfer_addr, word_off;
   logic              addr_done, data_ok, data_err;

   assign word_off = PLEN'(idx) << 2;

   // State, word index and data register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         data_q <= data_nxt;
      end
   end

   // Next state, transfer request and data capture
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      data_nxt   = data_q;
      addr_phase = 1'b0;
      data_phase = 1'b0;
      xfer_write = 1'b0;
      xfer_addr  = SRC_BASE + word_off;
      case (state)
         IDLE: state_nxt = RD_ADDR;
         RD_ADDR: begin
            addr_phase = 1'b1;
            if (addr_done) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            data_phase = 1'b1;
            if (data_err) begin
               state_nxt = ERROR;
            end else if (data_ok) begin
               data_nxt  = ahb4_hrdata_i;
               state_nxt = WR_ADDR;
            end
         end
         WR_ADDR: begin
            addr_phase = 1'b1;
            xfer_write = 1'b1;
            xfer_addr  = DST_BASE + word_off;
            if (addr_done) state_nxt = WR_DATA;
         end
         WR_DATA: begin
            data_phase = 1'b1;
            if (data_err) begin
               state_nxt = ERROR;
            end else if (data_ok) begin
`ifdef SOC_BOOTCOPY_VERIFY_EN
               // idx advances after readback so VR_ADDR still targets this word
               state_nxt = VR_ADDR;
`else
               idx_nxt   = idx + IDXW'(1);
               state_nxt = (idx == LAST_IDX) ? DONE : RD_ADDR;
`endif
            end
         end
`ifdef SOC_BOOTCOPY_VERIFY_EN
         VR_ADDR: begin
            addr_phase = 1'b1;
            xfer_addr  = DST_BASE + word_off;
            if (addr_done) state_nxt = VR_DATA;
         end
         VR_DATA: begin
            data_phase = 1'b1;
            if (data_err) begin
               state_nxt = ERROR;
            end else if (data_ok) begin
               if (ahb4_hrdata_i != data_q) begin
                  state_nxt = ERROR;
               end else begin
                  idx_nxt   = idx + IDXW'(1);
                  state_nxt = (idx == LAST_IDX) ? DONE : RD_ADDR;
               end
            end
         end
`endif
         DONE:    state_nxt = DONE;
         ERROR:   state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   soc_ahb_single_xfer #(.PLEN(PLEN)) u_xfer (
      .addr_phase (addr_phase),
      .data_phase (data_phase),
      .addr       (xfer_addr),
      .write      (xfer_write),
      .hready     (ahb4_hready_i),
      .hresp      (ahb4_hresp_i),
      .haddr      (ahb4_haddr_o),
      .hwrite     (ahb4_hwrite_o),
      .htrans     (ahb4_htrans_o),
      .addr_done  (addr_done),
      .data_ok    (data_ok),
      .data_err   (data_err)
   );

   assign ahb4_hwdata_o    = data_q;
   assign ahb4_hsize_o     = HSIZE_WORD;
   assign ahb4_hburst_o    = HBURST_SINGLE;
   assign ahb4_hprot_o     = HPROT_DATA;
   assign ahb4_hmastlock_o = 1'b0;

   // DONE and ERROR are absorbing, so these flags are sticky until rst
   assign cpu_rst_o = (state != DONE);
   assign done_o    = (state == DONE);
   assign error_o   = (state == ERROR);

endmodule

// File: tb/tb_soc_bootcopy.sv
// Bench for soc_bootcopy: AHB-Lite ROM/SRAM slave model with wait-state,
// error and readback-corruption injection, plus a wrap-address instance.
// Honours SOC_BOOTCOPY_VERIFY_EN to match the RTL build.
module tb_soc_bootcopy;

`ifdef SOC_BOOTCOPY_VERIFY_EN
   localparam int PER = 6;
`else
   localparam int PER = 4;
`endif
   localparam int W = 4;

   typedef struct {
      int rd_waits;
      int aw_waits;
      int err_word;
      int corrupt;
      int rst_at;
      int exp_done;
      int exp_err;
   } vec_t;

   logic        clk, rst;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hmastlock, hready, hresp;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        cpu_rst, done, error;

   logic [31:0] haddr2, hwdata2, hrdata2;
   logic        hwrite2, hmastlock2, hready2, hresp2;
   logic [2:0]  hsize2, hburst2;
   logic [3:0]  hprot2;
   logic [1:0]  htrans2;
   logic        cpu_rst2, done2, error2;

   int tests = 0;
   int fails = 0;

   int cfg_waits, cfg_aw, cfg_err_word, cfg_corrupt;
   int stab_bad, wt_cnt, aw_cnt, got_first;
   logic [31:0] first_addr, aw_addr, dp_haddr;
   logic        dp_valid, dp_write, dp_first;
   logic [31:0] dp_addr;
   logic [31:0] rom  [4];
   logic [31:0] sram [4];
   logic [31:0] wlog [4];
   int          wlog_n;

   soc_bootcopy #(.WORDS(W)) dut (
      .clk(clk), .rst(rst),
      .ahb4_haddr_o(haddr), .ahb4_hwdata_o(hwdata), .ahb4_hwrite_o(hwrite),
      .ahb4_hsize_o(hsize), .ahb4_hburst_o(hburst), .ahb4_hprot_o(hprot),
      .ahb4_htrans_o(htrans), .ahb4_hmastlock_o(hmastlock),
      .ahb4_hrdata_i(hrdata), .ahb4_hready_i(hready), .ahb4_hresp_i(hresp),
      .cpu_rst_o(cpu_rst), .done_o(done), .error_o(error)
   );

   soc_bootcopy #(.WORDS(W), .DST_BASE(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst),
      .ahb4_haddr_o(haddr2), .ahb4_hwdata_o(hwdata2), .ahb4_hwrite_o(hwrite2),
      .ahb4_hsize_o(hsize2), .ahb4_hburst_o(hburst2), .ahb4_hprot_o(hprot2),
      .ahb4_htrans_o(htrans2), .ahb4_hmastlock_o(hmastlock2),
      .ahb4_hrdata_i(hrdata2), .ahb4_hready_i(hready2), .ahb4_hresp_i(hresp2),
      .cpu_rst_o(cpu_rst2), .done_o(done2), .error_o(error2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait always-OK slave for the wrap instance; logs write addresses
   assign hready2 = 1'b1;
   assign hresp2  = 1'b0;
   assign hrdata2 = 32'hA5A5_0000;
   always @(negedge clk) begin
      if (rst) wlog_n = 0;
      else if (htrans2 == 2'b10 && hwrite2 && wlog_n < 4) begin
         wlog[wlog_n] = haddr2;
         wlog_n++;
      end
   end

   // Main slave: decides hready/hresp/hrdata for the current cycle at negedge
   always @(negedge clk) begin
      if (rst) begin
         hready = 1'b1; hresp = 1'b0; hrdata = '0;
         dp_valid = 1'b0; wt_cnt = 0; aw_cnt = 0; got_first = 0;
      end else if (dp_valid) begin
         if (htrans !== 2'b00) stab_bad++;
         if (dp_first) dp_haddr = haddr;
         else if (haddr !== dp_haddr) stab_bad++;
         dp_first = 1'b0;
         if (!dp_write && dp_addr < 32'h8000_0000 && wt_cnt < cfg_waits) begin
            hready = 1'b0; hresp = 1'b0; wt_cnt++;
         end else begin
            int widx;
            widx = int'((dp_addr - 32'h8000_0000) >> 2);
            hready = 1'b1; wt_cnt = 0; dp_valid = 1'b0;
            if (dp_write) begin
               if (widx == cfg_err_word) hresp = 1'b1;
               else begin
                  hresp = 1'b0;
                  if (widx >= 0 && widx < 4) sram[widx] = hwdata;
               end
            end else begin
               hresp = 1'b0;
               if (dp_addr >= 32'h8000_0000)
                  hrdata = (widx >= 0 && widx < 4) ?
                           (sram[widx] ^ ((widx == cfg_corrupt) ? 32'h1 : 32'h0)) : 32'h0;
               else
                  hrdata = rom[dp_addr[3:2]];
            end
         end
      end else begin
         hresp = 1'b0;
         if (htrans == 2'b10) begin
            if (!hwrite && haddr < 32'h8000_0000 && aw_cnt < cfg_aw) begin
               hready = 1'b0;
               if (aw_cnt == 0) aw_addr = haddr;
               else if (haddr !== aw_addr) stab_bad++;
               aw_cnt++;
            end else begin
               if (aw_cnt > 0 && (haddr !== aw_addr || hwrite !== 1'b0)) stab_bad++;
               hready = 1'b1; aw_cnt = 0;
               dp_valid = 1'b1; dp_addr = haddr; dp_write = hwrite; dp_first = 1'b1;
               if (got_first == 0) begin
                  first_addr = haddr;
                  got_first = 1;
               end
            end
         end else begin
            hready = 1'b1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int n, done_cyc, pair_bad, pulsed;
      rst = 1'b1;
      cfg_waits = v.rd_waits; cfg_aw = v.aw_waits;
      cfg_err_word = v.err_word; cfg_corrupt = v.corrupt;
      for (int i = 0; i < 4; i++) sram[i] = '0;
      stab_bad = 0; pair_bad = 0; pulsed = 0; done_cyc = -1; n = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         n++;
         if (pulsed == 0 && v.rst_at != 0 && n == v.rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check("midrst_htrans", int'(htrans), 0);
            check("midrst_haddr", int'(haddr), 0);
            check("midrst_cpu_rst", int'(cpu_rst), 1);
            @(negedge clk);
            rst = 1'b0; n = 0; pulsed = 1;
            continue;
         end
         if (cpu_rst !== !done) pair_bad++;
         if (done && done_cyc < 0) done_cyc = n;
         if (done || error) break;
      end
      repeat (3) @(negedge clk);
      $display("[TB] vector %0d", id);
      check("done_cycle", done_cyc, v.exp_done);
      check("error_o", int'(error), v.exp_err);
      check("done_o", int'(done), (v.exp_err != 0) ? 0 : 1);
      check("cpu_rst_o", int'(cpu_rst), v.exp_err);
      check("htrans_after", int'(htrans), 0);
      check("cpu_rst_done_pair", pair_bad, 0);
      check("bus_stable", stab_bad, 0);
      check("first_rd_addr", int'(first_addr), 0);
      if (v.exp_err == 0)
         for (int i = 0; i < 4; i++) check("sram_word", int'(sram[i]), int'(rom[i]));
   endtask

   initial begin
      vec_t vecs[$];
      rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
      cfg_waits = 0; cfg_aw = 0; cfg_err_word = -1; cfg_corrupt = -1;
      wlog_n = 0; stab_bad = 0; first_addr = '0;
      rst = 1'b1;
      //            rdw aw  err cor rst exp_done           exp_err
      vecs.push_back('{0, 0, -1, -1, 0,  1 + PER*W,          0});
      vecs.push_back('{2, 0, -1, -1, 0,  1 + PER*W + 2*W,    0});
      vecs.push_back('{0, 1, -1, -1, 0,  1 + PER*W + W,      0});
      vecs.push_back('{0, 0,  2, -1, 0,  -1,                 1});
      vecs.push_back('{0, 0, -1, -1, 10, 1 + PER*W,          0});
      vecs.push_back('{1, 0,  0, -1, 0,  -1,                 1});
`ifdef SOC_BOOTCOPY_VERIFY_EN
      vecs.push_back('{0, 0, -1,  1, 0,  -1,                 1});
`endif

      repeat (2) @(negedge clk);
      check("rst_htrans", int'(htrans), 0);
      check("rst_haddr", int'(haddr), 0);
      check("rst_hwrite", int'(hwrite), 0);
      check("rst_hwdata", int'(hwdata), 0);
      check("rst_cpu_rst", int'(cpu_rst), 1);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      check("hsize", int'(hsize), 2);
      check("hprot", int'(hprot), 3);

      foreach (vecs[i]) begin
         run_vec(i, vecs[i]);
         if (i == 0) begin
            check("wrap_count", wlog_n, 4);
            check("wrap_addr0", int'(wlog[0]), int'(32'hFFFF_FFF8));
            check("wrap_addr1", int'(wlog[1]), int'(32'hFFFF_FFFC));
            check("wrap_addr2", int'(wlog[2]), 0);
            check("wrap_addr3", int'(wlog[3]), 4);
            check("wrap_done", int'(done2), 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/soc_bootcopy.md
# soc_bootcopy

Boot-time copy engine sitting directly downstream of the boot ROM. After reset it acts as an AHB-Lite master and reads `WORDS` 32-bit words from the boot ROM window. It writes each word into local SRAM at `DST_BASE`, holding the CPU in reset until the image is in place. On completion it releases `cpu_rst_o` and flags `done_o`; any bus error parks it in an error state with the CPU still held.

## Interface
- `PLEN`, 32, physical address width
- `XLEN`, 32, data width (only 32 supported)
- `SRC_BASE`, 32'h0000_0000, boot ROM base address
- `DST_BASE`, 32'h8000_0000, SRAM destination base address
- `WORDS`, 64, number of words copied (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ahb4_haddr_o`  out  PLEN  transfer address
- `ahb4_hwdata_o`  out  XLEN  write data
- `ahb4_hwrite_o`  out  1  1 = write
- `ahb4_hsize_o`  out  3  constant 3'b010 (word)
- `ahb4_hburst_o`  out  3  constant 3'b000 (SINGLE)
- `ahb4_hprot_o`  out  4  constant 4'b0011
- `ahb4_htrans_o`  out  2  2'b10 NONSEQ in address phase, else 2'b00 IDLE
- `ahb4_hmastlock_o`  out  1  constant 0
- `ahb4_hrdata_i`  in  XLEN  read data
- `ahb4_hready_i`  in  1  transfer ready
- `ahb4_hresp_i`  in  1  1 = ERROR
- `cpu_rst_o`  out  1  CPU reset hold, high until copy complete
- `done_o`  out  1  copy complete, sticky
- `error_o`  out  1  bus error (or verify mismatch), sticky

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, [VR_ADDR, VR_DATA], DONE, ERROR.
- IDLE: entered on reset; moves to RD_ADDR on the next cycle unconditionally.
- RD_ADDR:
  - Drive `haddr = SRC_BASE + 4*idx`, NONSEQ, `hwrite=0`.
  - Advance to RD_DATA on a cycle where `hready_i=1`; otherwise hold all address-phase signals stable.
- RD_DATA:
  - Drive IDLE.
  - When `hready_i=1` and `hresp_i=0`, capture `hrdata_i` into the data register and go to WR_ADDR.
- WR_ADDR: drive `haddr = DST_BASE + 4*idx`, NONSEQ, `hwrite=1`; advance on `hready_i=1`.
- WR_DATA:
  - Drive `hwdata` from the data register, hold it until `hready_i=1`, then increment `idx`.
  - If `idx` was `WORDS-1`, go to DONE; else go to RD_ADDR.
- Any data phase with `hready_i=1` and `hresp_i=1` goes to ERROR.
- DONE: `cpu_rst_o=0`, `done_o=1`, bus IDLE forever (until `rst`).
- ERROR: `error_o=1`, `cpu_rst_o=1`, bus IDLE forever.
- `idx` is $clog2(WORDS) bits wide; address arithmetic is PLEN-bit with wrap-around, with no overflow check.

## Timing
- Reset values: `htrans=IDLE`, `haddr=0`, `hwrite=0`, `hwdata=0`, `cpu_rst_o=1`, `done_o=0`, `error_o=0`.
- Zero-wait bus: 4 cycles per word.
- `done_o` rises exactly `1+4*WORDS` cycles after the first cycle with `rst=0`.
- Each wait cycle (`hready_i=0`) adds one cycle.
- `rst` asserted mid-copy: next edge returns to IDLE with reset values, and the copy restarts from `idx=0`.
- `cpu_rst_o` and `done_o` change on the same edge.

## Configuration
- `SOC_BOOTCOPY_VERIFY_EN` defined: after each WR_DATA, VR_ADDR/VR_DATA read back the destination address.
  - A mismatch with the data register goes to ERROR.
  - Per-word cost is 6 cycles; `done_o` at `1+6*WORDS`.
- Undefined: no readback states; cost is 4 cycles per word.

## Structure
- `soc_bootcopy_pkg` holds:
  - the FSM state enum;
  - HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE constants.
- One natural sub-module: `soc_ahb_single_xfer`, a one-transfer address/data-phase sequencer with hready/hresp handling, reused for read, write and verify.

## Test plan
- WORDS=4, ROM words 0x11,0x22,0x33,0x44, zero-wait -> SRAM 0x8000_0000..0x8000_000C holds 0x11..0x44; `done_o` rises at cycle 17; `cpu_rst_o` falls on the same edge.
- Two wait cycles inserted on every RD_DATA -> `done_o` at cycle 25; `haddr`/`htrans` stable through all waits.
- `hresp_i=1` on the write data phase of word 2 -> `error_o=1`, `cpu_rst_o=1`, `done_o=0`, htrans IDLE thereafter.
- `rst` pulsed during word 3 -> copy restarts at `haddr=SRC_BASE`; final SRAM contents correct; `done_o` at cycle 17 after release.
- VERIFY_EN, SRAM model corrupts word 1 readback (0x22->0x23) -> `error_o=1` after VR_DATA of word 1.
- `DST_BASE=32'hFFFF_FFF8`, WORDS=4 -> write addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
